// File: rtl/serial_adder_arbiter.sv
// Round-robin sequencer that shares one serial adder among R requesters.
// Grant to ack takes 2N+2 cycles plus the adder's done delay; each req is held until its ack.
module serial_adder_arbiter #(
  parameter int N       = 4,
  parameter int R       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [R-1:0]   req,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   ack,
  output logic [N-1:0]   sum_out,
  output logic           err,
  output logic           busy,
  output logic           sa_start,
  output logic           sa_si,
  input  logic           sa_done,
  input  logic [N-1:0]   sa_result
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam int BW = $clog2(2*N) + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(2*N - 1);
  localparam logic [WW-1:0] WD_MAX   = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  ptr, gidx, pick, cand;
  logic           pick_vld;
  int             sum_i;
  logic [2*N-1:0] shreg;
  logic [BW-1:0]  bit_cnt;
  logic [WW-1:0]  wd_cnt;
  logic           load, last_bit, timeout, done_ok, done_to;

  // Search ptr+1, ptr+2, ... modulo R; the last winner gets lowest priority.
  always_comb begin
    pick     = ptr;
    pick_vld = 1'b0;
    sum_i    = 0;
    cand     = '0;
    for (int i = 1; i <= R; i++) begin
      sum_i = int'(ptr) + i;
      if (sum_i >= R) sum_i = sum_i - R;
      cand = PW'(sum_i);
      if (!pick_vld && req[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = START;
      START:   state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = WAIT;
      WAIT:    if (done_ok || done_to) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A done pulse beats a simultaneous watchdog expiry.
  always_comb begin
    load     = (state == IDLE) && pick_vld;
    last_bit = (bit_cnt == LAST_BIT);
    timeout  = (wd_cnt == WD_MAX);
    done_ok  = (state == WAIT) && sa_done;
    done_to  = (state == WAIT) && !sa_done && timeout;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt      <= '0;
      ack      <= '0;
      sum_out  <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      sa_start <= 1'b0;
      sa_si    <= 1'b0;
      ptr      <= PW'(R - 1);
      gidx     <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            gnt      <= R'(1) << pick;
            gidx     <= pick;
            shreg    <= {req_b[pick*N +: N], req_a[pick*N +: N]};
            sa_start <= 1'b1;
            busy     <= 1'b1;
          end
        end
        START: begin
          sa_start <= 1'b0;
          sa_si    <= shreg[0];
          shreg    <= shreg >> 1;
          bit_cnt  <= '0;
        end
        SHIFT: begin
          if (last_bit) begin
            sa_si  <= 1'b0;
            wd_cnt <= '0;
          end else begin
            sa_si   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        WAIT: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (done_ok) begin
            sum_out <= sa_result;
            ack     <= gnt;
          end else if (done_to) begin
            sum_out <= '0;
            ack     <= gnt;
            err     <= 1'b1;
          end
        end
        RESP: begin
          ack  <= '0;
          err  <= 1'b0;
          gnt  <= '0;
          busy <= 1'b0;
          ptr  <= gidx;
        end
        default: ;
      endcase
    end
  end

endmodule
